// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame link: receiver state encoding and default framing constants.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/serial_frame_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Asynchronous-serial frame receiver: start / DATA_BITS data (LSB first) / stop,
// centre-sampled from a fixed clock-per-bit divider.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic                 rx_s;
    logic                 rx_d;
    logic                 sync_ready;
    logic                 armed;
    logic                 fall;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] sh;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rx_s)
    );

    // Goes high once the synchronizer holds real line samples instead of its reset value.
    sync_2ff #(.RESET_VAL(1'b0)) u_ready (
        .clk (clk),
        .rst (rst),
        .d   (1'b1),
        .q   (sync_ready)
    );

    // A falling edge only counts after the real line has been seen high,
    // so a line held low through reset cannot start a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_d  <= 1'b1;
            armed <= 1'b0;
        end else begin
            rx_d  <= rx_s;
            armed <= armed | (sync_ready & rx_s);
        end
    end

    assign fall = armed & rx_d & ~rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (cnt == CNT_LAST && idx == IDX_LAST) state_nxt = STOP;
            STOP:  if (cnt == CNT_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        idx <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        sh  <= {rx_s, sh[DATA_BITS-1:1]};
                        if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_out   <= sh;
                            data_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: directed link scenarios followed by randomized frames.
module tb_serial_frame_rx;

    localparam int CPB     = 16;
    localparam int DB      = 8;
    // rx_in edge to strobe: 2 sync cycles, half-bit start confirm, DB data + stop bits, registered strobe.
    localparam int LATENCY = 2 + CPB / 2 + (DB + 1) * CPB + 1;

    typedef struct {
        bit              is_err;
        logic [DB-1:0]   data;
        int unsigned     cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;

    int unsigned   cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    exp_t          sb[$];
    logic [DB-1:0] exp_out = '0;

    serial_frame_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            exp_out = '0;
        end else begin
            if (data_valid || frame_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", {30'b0, frame_err, data_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("strobe_kind", {30'b0, frame_err, data_valid}, e.is_err ? 32'd2 : 32'd1);
                    check("strobe_cycle", cyc, e.cyc);
                    check("busy_at_strobe", {31'b0, busy}, 32'd0);
                    if (!e.is_err) exp_out = e.data;
                end
            end
            check("data_out", {24'b0, data_out}, {24'b0, exp_out});
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input int gap);
        exp_t e;
        e.is_err = !stop_bit;
        e.data   = d;
        e.cyc    = cyc + LATENCY;
        sb.push_back(e);
        rx_in = 1'b0;
        hold(CPB);
        for (int i = 0; i < DB; i++) begin
            rx_in = d[i];
            hold(CPB);
        end
        rx_in = stop_bit;
        hold(CPB);
        rx_in = 1'b1;
        hold(gap);
    endtask

    // Short low pulse: START lasts until the half-bit confirm, then the receiver drops back to idle.
    task automatic glitch(input int len);
        rx_in = 1'b0;
        hold(len);
        rx_in = 1'b1;
        hold(2 + CPB / 2 - len);
        check("glitch_in_start", {31'b0, busy}, 32'd1);
        hold(1);
        check("glitch_back_idle", {31'b0, busy}, 32'd0);
        hold(2 * CPB);
    endtask

    task automatic check_cleared(input string name);
        check({name, "_data_out"}, {24'b0, data_out}, 32'd0);
        check({name, "_valid"}, {31'b0, data_valid}, 32'd0);
        check({name, "_err"}, {31'b0, frame_err}, 32'd0);
        check({name, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int          r;
        logic        stop_bit;
        int          gap;
        logic [DB-1:0] d;

        rst   = 1'b1;
        rx_in = 1'b1;
        hold(3);
        check_cleared("reset");
        rst = 1'b0;
        hold(2 * CPB);

        send_frame(8'hA5, 1'b1, CPB);
        glitch(4);
        send_frame(8'h3C, 1'b0, CPB);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, CPB);

        // Reset 80 cycles into a 0x5A frame; the partial frame must vanish.
        d = 8'h5A;
        rx_in = 1'b0;
        hold(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            hold(CPB);
        end
        check("midframe_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_cleared("midframe_reset");
        rx_in = 1'b1;
        hold(3);
        rst = 1'b0;
        hold(2 * CPB);
        send_frame(8'h5A, 1'b1, CPB);

        // Line low across reset release must not start a frame.
        rx_in = 1'b0;
        rst   = 1'b1;
        hold(3);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hold(CPB);
            check("held_low_idle", {31'b0, busy}, 32'd0);
        end
        rx_in = 1'b1;
        hold(CPB);
        send_frame(8'hC3, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                glitch($urandom_range(1, CPB / 2 - 2));
            end else begin
                stop_bit = (r != 1);
                gap = stop_bit ? ($urandom_range(0, 2) * CPB + $urandom_range(0, CPB - 1))
                               : (CPB + $urandom_range(0, CPB - 1));
                send_frame(DB'($urandom), stop_bit, gap);
            end
        end

        for (int i = 0; i < 4 * LATENCY && sb.size() > 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
